// File: rtl/median_stream_ctrl.sv
// median_stream_ctrl: frame sequencer for an external 5-tap rank-order
// (median) datapath. Replicates the first and last sample of every frame
// twice so an N-sample frame produces exactly N medians, and applies
// downstream backpressure by freezing the datapath while an output waits.
module median_stream_ctrl #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          dp_push,
  output logic [DW-1:0] dp_din,
  input  logic [DW-1:0] dp_median,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic [15:0]   frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRELOAD = 2'd1,
    S_RUN     = 2'd2,
    S_FLUSH   = 2'd3
  } state_t;

  state_t        r_state;
  logic [2:0]    r_pcnt;
  logic [DW-1:0] r_last;
  logic          r_phase;
  logic          r_first_last;
  logic          r_out_valid;
  logic          r_out_last;
  logic [15:0]   r_frame_cnt;

  logic          w_stall;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_push;
  logic [DW-1:0] w_din;
  logic          w_produce;
  logic [2:0]    w_pcnt_next;

  // Handshake, push and output-producing decode for the current state.
  // rst_n gating keeps in_ready/dp_push low for the whole reset interval.
  always_comb begin
    w_stall     = r_out_valid & ~out_ready;
    w_in_ready  = 1'b0;
    w_push      = 1'b0;
    w_din       = r_last;
    case (r_state)
      S_IDLE, S_RUN: begin
        w_in_ready = rst_n & ~w_stall;
        w_push     = in_valid & w_in_ready;
        w_din      = in_data;
      end
      S_PRELOAD, S_FLUSH: begin
        w_push = rst_n & ~w_stall;
        w_din  = r_last;
      end
      default: begin
        w_in_ready = 1'b0;
        w_push     = 1'b0;
      end
    endcase
    w_accept    = in_valid & w_in_ready;
    w_pcnt_next = (r_pcnt == 3'd5) ? 3'd5 : 3'(r_pcnt + 3'd1);
    // The datapath window is full once five pushes of this frame are in;
    // an IDLE push is always a frame's first, so it never produces.
    w_produce   = w_push && (r_state != S_IDLE) && (r_pcnt >= 3'd4);
  end

  // Frame sequencing FSM plus registered output-valid/last and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pcnt       <= '0;
      r_last       <= '0;
      r_phase      <= 1'b0;
      r_first_last <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_last       <= in_data;
            r_pcnt       <= 3'd1;
            r_first_last <= in_last;
            r_phase      <= 1'b0;
            r_state      <= S_PRELOAD;
          end
        end
        S_PRELOAD: begin
          if (w_push) begin
            r_pcnt <= w_pcnt_next;
            if (r_phase) begin
              r_phase <= 1'b0;
              r_state <= r_first_last ? S_FLUSH : S_RUN;
            end else begin
              r_phase <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_last <= in_data;
            r_pcnt <= w_pcnt_next;
            if (in_last) begin
              r_phase <= 1'b0;
              r_state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (w_push) begin
            r_pcnt <= w_pcnt_next;
            if (r_phase) begin
              r_phase     <= 1'b0;
              r_frame_cnt <= 16'(r_frame_cnt + 16'd1);
              r_state     <= S_IDLE;
            end else begin
              r_phase <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A producing push wins over a same-cycle handshake so outputs can
      // stream one per cycle.
      if (w_produce) begin
        r_out_valid <= 1'b1;
        r_out_last  <= (r_state == S_FLUSH) && r_phase;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign dp_push   = w_push;
  assign dp_din    = w_din;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_data  = dp_median;
  assign busy      = (r_state != S_IDLE);
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_median_stream_ctrl.sv
// Directed bench for median_stream_ctrl with a behavioural 5-tap median
// datapath attached to the dp_* ports.
module tb_median_stream_ctrl;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          dp_push;
  logic [DW-1:0] dp_din;
  logic [DW-1:0] dp_median = 8'h5A;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic [15:0]   frame_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] push_q[$];
  logic [DW-1:0] out_q[$];
  logic          last_q[$];

  always #5 clk = ~clk;

  median_stream_ctrl #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .dp_push(dp_push), .dp_din(dp_din), .dp_median(dp_median),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  // Behavioural datapath: window of 5, registered median, stale-at-start.
  logic [DW-1:0] dp_win[5] = '{8'hAA, 8'h11, 8'hEE, 8'h22, 8'hCC};
  logic          s_push = 1'b0;
  logic [DW-1:0] s_din = '0;

  function automatic logic [DW-1:0] median5(input logic [DW-1:0] w[5]);
    logic [DW-1:0] a[5];
    logic [DW-1:0] t;
    for (int i = 0; i < 5; i++) a[i] = w[i];
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    return a[2];
  endfunction

  // Mid-cycle sampling of pushes and output handshakes.
  always @(negedge clk) begin
    s_push = dp_push;
    s_din  = dp_din;
    if (dp_push) push_q.push_back(dp_din);
    if (out_valid && out_ready) begin
      out_q.push_back(out_data);
      last_q.push_back(out_last);
    end
  end

  always @(posedge clk) begin
    if (s_push) begin
      for (int i = 4; i > 0; i--) dp_win[i] = dp_win[i-1];
      dp_win[0] = s_din;
      dp_median <= median5(dp_win);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic clear_q();
    push_q.delete();
    out_q.delete();
    last_q.delete();
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l, output int waited);
    bit done;
    done   = 1'b0;
    waited = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      waited = i + 1;
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_accept: data=%0h not accepted, got timeout after %0d cycles, required acceptance", d, waited);
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!busy && !out_valid) done = 1'b1;
    end
    @(posedge clk); #1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_idle: busy=%0b out_valid=%0b, required both 0", busy, out_valid);
    end
  endtask

  task automatic test_reset();
    int w;
    in_valid = 1'b1; in_data = 8'h33;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b required 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %0b required 0", out_last); end
    checks++; if (dp_push !== 1'b0) begin errors++; $display("FAIL rst_dp_push: got %0b required 0", dp_push); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b required 0", busy); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d required 0", frame_cnt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %0b required 0", in_ready); end
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready: got %0b required 1", in_ready); end
    @(posedge clk); #1;
    w = 0;
  endtask

  task automatic test_frame5();
    logic [DW-1:0] exp_p[9] = '{10, 10, 10, 50, 20, 40, 30, 30, 30};
    logic [DW-1:0] exp_o[5] = '{10, 20, 30, 30, 30};
    logic [DW-1:0] din[5]   = '{10, 50, 20, 40, 30};
    int w;
    clear_q();
    for (int i = 0; i < 5; i++) send(din[i], (i == 4), w);
    wait_idle();
    checks++; if (push_q.size() != 9) begin errors++; $display("FAIL f5_push_count: got %0d required 9", push_q.size()); end
    for (int i = 0; i < 9 && i < push_q.size(); i++) begin
      checks++; if (push_q[i] !== exp_p[i]) begin errors++; $display("FAIL f5_dp_din[%0d]: got %0d required %0d", i, push_q[i], exp_p[i]); end
    end
    checks++; if (out_q.size() != 5) begin errors++; $display("FAIL f5_out_count: got %0d required 5", out_q.size()); end
    for (int i = 0; i < 5 && i < out_q.size(); i++) begin
      checks++; if (out_q[i] !== exp_o[i]) begin errors++; $display("FAIL f5_out[%0d]: got %0d required %0d", i, out_q[i], exp_o[i]); end
      checks++; if (last_q[i] !== (i == 4)) begin errors++; $display("FAIL f5_last[%0d]: got %0b required %0b", i, last_q[i], (i == 4)); end
    end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL f5_frame_cnt: got %0d required 1", frame_cnt); end
  endtask

  task automatic test_frame1();
    int w;
    clear_q();
    send(8'd77, 1'b1, w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL f1_in_ready_low[%0d]: got %0b required 0", i, in_ready); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL f1_in_ready_back: got %0b required 1", in_ready); end
    @(posedge clk); #1;
    wait_idle();
    checks++; if (push_q.size() != 5) begin errors++; $display("FAIL f1_push_count: got %0d required 5", push_q.size()); end
    for (int i = 0; i < push_q.size(); i++) begin
      checks++; if (push_q[i] !== 8'd77) begin errors++; $display("FAIL f1_dp_din[%0d]: got %0d required 77", i, push_q[i]); end
    end
    checks++; if (out_q.size() != 1) begin errors++; $display("FAIL f1_out_count: got %0d required 1", out_q.size()); end
    if (out_q.size() > 0) begin
      checks++; if (out_q[0] !== 8'd77) begin errors++; $display("FAIL f1_out: got %0d required 77", out_q[0]); end
      checks++; if (last_q[0] !== 1'b1) begin errors++; $display("FAIL f1_last: got %0b required 1", last_q[0]); end
    end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL f1_frame_cnt: got %0d required 2", frame_cnt); end
  endtask

  task automatic test_frame2();
    logic [DW-1:0] exp_o[2] = '{5, 200};
    int w;
    clear_q();
    send(8'd5, 1'b0, w);
    send(8'd200, 1'b1, w);
    wait_idle();
    checks++; if (out_q.size() != 2) begin errors++; $display("FAIL f2_out_count: got %0d required 2", out_q.size()); end
    for (int i = 0; i < 2 && i < out_q.size(); i++) begin
      checks++; if (out_q[i] !== exp_o[i]) begin errors++; $display("FAIL f2_out[%0d]: got %0d required %0d", i, out_q[i], exp_o[i]); end
      checks++; if (last_q[i] !== (i == 1)) begin errors++; $display("FAIL f2_last[%0d]: got %0b required %0b", i, last_q[i], (i == 1)); end
    end
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL f2_frame_cnt: got %0d required 3", frame_cnt); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] din[8]    = '{9, 3, 7, 1, 8, 2, 6, 4};
    logic [DW-1:0] exp_o[8]  = '{9, 7, 7, 3, 6, 4, 4, 4};
    logic [DW-1:0] exp_p[12] = '{9, 9, 9, 3, 7, 1, 8, 2, 6, 4, 4, 4};
    int w;
    clear_q();
    for (int i = 0; i < 3; i++) send(din[i], 1'b0, w);
    // First output (median 9) is now pending; hold it for 6 cycles.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = din[3]; in_last = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (dp_push !== 1'b0) begin errors++; $display("FAIL stall_dp_push[%0d]: got %0b required 0", i, dp_push); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %0b required 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid[%0d]: got %0b required 1", i, out_valid); end
      checks++; if (out_data !== 8'd9) begin errors++; $display("FAIL stall_out_data[%0d]: got %0d required 9", i, out_data); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 3; i < 8; i++) send(din[i], (i == 7), w);
    wait_idle();
    checks++; if (push_q.size() != 12) begin errors++; $display("FAIL stall_push_count: got %0d required 12", push_q.size()); end
    for (int i = 0; i < 12 && i < push_q.size(); i++) begin
      checks++; if (push_q[i] !== exp_p[i]) begin errors++; $display("FAIL stall_dp_din[%0d]: got %0d required %0d", i, push_q[i], exp_p[i]); end
    end
    checks++; if (out_q.size() != 8) begin errors++; $display("FAIL stall_out_count: got %0d required 8", out_q.size()); end
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      checks++; if (out_q[i] !== exp_o[i]) begin errors++; $display("FAIL stall_out[%0d]: got %0d required %0d", i, out_q[i], exp_o[i]); end
      checks++; if (last_q[i] !== (i == 7)) begin errors++; $display("FAIL stall_last[%0d]: got %0b required %0b", i, last_q[i], (i == 7)); end
    end
    checks++; if (frame_cnt !== 16'd4) begin errors++; $display("FAIL stall_frame_cnt: got %0d required 4", frame_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] exp_o[3] = '{1, 2, 3};
    logic [DW-1:0] exp_p[7] = '{1, 1, 1, 2, 3, 3, 3};
    int w;
    clear_q();
    send(8'd4, 1'b0, w);
    send(8'd5, 1'b0, w);
    send(8'd6, 1'b0, w);
    send(8'd7, 1'b0, w);
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %0b required 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rmid_out_last: got %0b required 0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %0b required 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready: got %0b required 0", in_ready); end
    checks++; if (dp_push !== 1'b0) begin errors++; $display("FAIL rmid_dp_push: got %0b required 0", dp_push); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rmid_frame_cnt: got %0d required 0", frame_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_q();
    send(8'd1, 1'b0, w);
    send(8'd2, 1'b0, w);
    send(8'd3, 1'b1, w);
    wait_idle();
    checks++; if (push_q.size() != 7) begin errors++; $display("FAIL rmid_push_count: got %0d required 7", push_q.size()); end
    for (int i = 0; i < 7 && i < push_q.size(); i++) begin
      checks++; if (push_q[i] !== exp_p[i]) begin errors++; $display("FAIL rmid_dp_din[%0d]: got %0d required %0d", i, push_q[i], exp_p[i]); end
    end
    checks++; if (out_q.size() != 3) begin errors++; $display("FAIL rmid_out_count: got %0d required 3", out_q.size()); end
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      checks++; if (out_q[i] !== exp_o[i]) begin errors++; $display("FAIL rmid_out[%0d]: got %0d required %0d", i, out_q[i], exp_o[i]); end
      checks++; if (last_q[i] !== (i == 2)) begin errors++; $display("FAIL rmid_last[%0d]: got %0b required %0b", i, last_q[i], (i == 2)); end
    end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL rmid_frame_cnt: got %0d required 1", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_o[3] = '{8'hFF, 8'h00, 8'd3};
    logic          exp_l[3] = '{1'b0, 1'b1, 1'b1};
    int w;
    // Fresh reset so the frame count starts from zero for this scenario.
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_q();
    send(8'hFF, 1'b0, w);
    send(8'h00, 1'b1, w);
    // Two FLUSH cycles, then IDLE accepts on the very next cycle.
    send(8'd3, 1'b1, w);
    checks++; if (w != 3) begin errors++; $display("FAIL b2b_accept_gap: got %0d cycles required 3", w); end
    wait_idle();
    checks++; if (out_q.size() != 3) begin errors++; $display("FAIL b2b_out_count: got %0d required 3", out_q.size()); end
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      checks++; if (out_q[i] !== exp_o[i]) begin errors++; $display("FAIL b2b_out[%0d]: got %0h required %0h", i, out_q[i], exp_o[i]); end
      checks++; if (last_q[i] !== exp_l[i]) begin errors++; $display("FAIL b2b_last[%0d]: got %0b required %0b", i, last_q[i], exp_l[i]); end
    end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL b2b_frame_cnt: got %0d required 2", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_frame5();
    test_frame1();
    test_frame2();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/median_stream_ctrl.md
MEDIAN_STREAM_CTRL -- requirements
Module: median_stream_ctrl

Interface
REQ-001 Parameter DW, default 8, sample width in bits; supported range 2..16.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  upstream sample valid.
REQ-005 in_ready  output  1  controller accepts the sample this cycle.
REQ-006 in_data  input  DW  upstream sample.
REQ-007 in_last  input  1  sample is the final one of its frame.
REQ-008 dp_push  output  1  advances the external 5-tap rank-order datapath by one sample this cycle.
REQ-009 dp_din  output  DW  sample pushed into the datapath; meaningful only when dp_push=1.
REQ-010 dp_median  input  DW  datapath median; registered, and reflects a push on the cycle after it.
REQ-011 out_valid  output  1  filtered sample valid.
REQ-012 out_ready  input  1  downstream accepts the filtered sample.
REQ-013 out_data  output  DW  filtered sample; driven directly from dp_median.
REQ-014 out_last  output  1  the filtered sample is the last of its frame.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 frame_cnt  output  16  number of completed frames; wraps from 0xFFFF to 0.

Function
REQ-017 Output k of an N-sample frame SHALL equal median(x[k-2..k+2]), with indices clamped to 0..N-1 (replicate padding).
- Every frame of N>=1 samples yields exactly N outputs.
REQ-018 The FSM SHALL have four states: IDLE, PRELOAD, RUN, FLUSH.
REQ-019 IDLE: on acceptance, push in_data, store it in last_r, set pcnt=1, go to PRELOAD.
REQ-020 PRELOAD: push last_r on exactly 2 consecutive stall-free cycles; in_ready=0.
- If the first sample had in_last=1, go to FLUSH afterwards; otherwise go to RUN.
REQ-021 RUN: on each acceptance, push in_data and update last_r.
- If in_last=1, go to FLUSH.
REQ-022 FLUSH: push last_r on exactly 2 stall-free cycles, then return to IDLE.
- frame_cnt increments on the second FLUSH push.
REQ-023 in_ready SHALL be 1 only in IDLE or RUN, and only when the stall condition is false.
REQ-024 Stall condition: out_valid=1 and out_ready=0.
- No dp_push is issued while stalled, whatever the state.
- dp_push = in_valid&in_ready in IDLE/RUN; dp_push = !stall in PRELOAD/FLUSH.
REQ-025 pcnt SHALL count pushes within a frame.
- Saturates at 5.
- Cleared when a frame's first sample is accepted.
REQ-026 A push that brings pcnt to 5, or occurs with pcnt already 5, SHALL set out_valid=1 on the next cycle.
REQ-027 out_valid SHALL clear on an out_ready handshake unless a producing push occurred in the same cycle.
- Back-to-back outputs: 1 per cycle when out_ready is held high.
REQ-028 out_last SHALL be set together with the out_valid produced by the second FLUSH push; it is cleared otherwise.
REQ-029 Latency from a sample's acceptance to the output it completes SHALL be 1 cycle.
- The datapath completes output k-2 when sample k is accepted.
REQ-030 A new frame's first sample MAY be accepted in IDLE on the cycle after the final FLUSH push; no gap cycle is required.
REQ-031 in_data/in_last SHALL be ignored when in_ready=0.
- in_valid may drop at any time without a protocol error.

Reset
REQ-032 While rst_n=0, the following SHALL be held at their reset values:
- state=IDLE, pcnt=0, last_r=0
- out_valid=0, out_last=0, dp_push=0, busy=0, frame_cnt=0, in_ready=0
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no further output.
- The first frame after reset is processed correctly even though the datapath contents are stale, because 5 pushes precede the first output.

Verification
REQ-034 N=5 frame {10,50,20,40,30}, out_ready=1:
- dp_din = 10,10,10,50,20,40,30,30,30.
- Outputs 10,20,30,30,30; out_last on the 5th; frame_cnt=1.
REQ-035 N=1 frame {77}:
- 5 pushes of 77.
- One output 77 with out_last=1.
- in_ready=0 for 4 cycles after acceptance.
REQ-036 N=2 frame {5,200}: outputs 5 then 200; out_last on 200.
REQ-037 out_ready=0 for 6 cycles while out_valid=1 mid-RUN:
- No dp_push; out_data stable; in_ready=0.
- The stream resumes with no lost or duplicated outputs.
REQ-038 rst_n pulsed low mid-RUN, then frame {1,2,3}:
- All outputs clear immediately.
- The new frame yields 1,2,3 with out_last on 3.
REQ-039 Back-to-back frames {0xFF,0x00} then {3}:
- Outputs 0xFF,0x00 then 3.
- Two out_last pulses; frame_cnt=2.
